// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // Two's-complement negate when neg is set; used for magnitudes and result signs.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: MSB-first shift-add multiply, or a
// restoring-division step on a 33-bit partial remainder.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  input  logic        msb_i,
  input  logic        is_div_i,
  output logic [63:0] acc_o,
  output logic        qbit_o
);

  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {acc_i[31:0], msb_i};
    diff    = {1'b0, shifted} - {2'b00, operand_i};
    acc_o   = '0;
    qbit_o  = 1'b0;
    if (is_div_i) begin
      // Borrow out of the 34-bit subtraction means the trial did not fit.
      if (!diff[33]) begin
        acc_o  = {31'd0, diff[32:0]};
        qbit_o = 1'b1;
      end else begin
        acc_o  = {31'd0, shifted};
      end
    end else begin
      acc_o = {acc_i[62:0], 1'b0} + (msb_i ? {32'd0, operand_i} : 64'd0);
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit. Stalls the pipeline while computing and
// returns the result with a one-cycle done pulse.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   shreg_q, shreg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  muldiv_op_e        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic [2:0]        op_bits;
  logic              is_div_in, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div0_hit, ovf_hit, fast_hit;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] step_acc, prod;
  logic              step_qbit;
  logic [XLEN-1:0]   step_shreg, quot, rem_lo, final_res;

  // Operand signedness: MULHSU is the only mixed case; unsigned ops have funct3[0] set
  // on the divide side and funct3==011 on the multiply side.
  always_comb begin
    is_div_in = i_funct3[2];
    a_signed  = is_div_in ? !i_funct3[0] : (i_funct3 != OP_MULHU);
    b_signed  = is_div_in ? !i_funct3[0] : !i_funct3[1];
    a_neg     = a_signed & i_rs1_data[XLEN-1];
    b_neg     = b_signed & i_rs2_data[XLEN-1];
    a_mag     = cond_neg32(i_rs1_data, a_neg);
    b_mag     = cond_neg32(i_rs2_data, b_neg);
    div0_hit  = is_div_in && (i_rs2_data == '0);
    ovf_hit   = is_div_in && !i_funct3[0] && (i_rs1_data == INT_MIN) && (i_rs2_data == '1);
    fast_hit  = div0_hit || ovf_hit;
    if (div0_hit) fast_res = i_funct3[1] ? i_rs1_data : DIV0_QUOT;
    else          fast_res = i_funct3[1] ? '0 : INT_MIN;
  end

  assign op_bits = op_q;

  muldiv_step u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .msb_i     (shreg_q[XLEN-1]),
    .is_div_i  (op_bits[2]),
    .acc_o     (step_acc),
    .qbit_o    (step_qbit)
  );

  assign step_shreg = {shreg_q[XLEN-2:0], step_qbit};

  always_comb begin
    prod      = neg_quot_q ? (~step_acc + 64'd1) : step_acc;
    quot      = cond_neg32(step_shreg, neg_quot_q);
    rem_lo    = cond_neg32(step_acc[XLEN-1:0], neg_rem_q);
    final_res = '0;
    if (op_bits[2])           final_res = op_bits[1] ? rem_lo : quot;
    else if (op_q == OP_MUL)  final_res = prod[XLEN-1:0];
    else                      final_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    rd_d       = rd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    rd_out_d   = rd_out_q;
    case (state_q)
      IDLE: begin
        if (i_start && !i_flush) begin
          op_d = muldiv_op_e'(i_funct3);
          rd_d = i_rd_addr;
          if (fast_hit) begin
            state_d  = DONE;
            result_d = fast_res;
            rd_out_d = i_rd_addr;
          end else begin
            state_d    = CALC;
            cnt_d      = '1;
            acc_d      = '0;
            shreg_d    = is_div_in ? a_mag : b_mag;
            opnd_d     = is_div_in ? b_mag : a_mag;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
          end
        end
      end
      CALC: begin
        acc_d   = step_acc;
        shreg_d = step_shreg;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = final_res;
          rd_out_d = rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A redirect kills whatever is in flight and leaves the last result untouched.
    if (i_flush) begin
      state_d  = IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      shreg_q    <= '0;
      opnd_q     <= '0;
      op_q       <= OP_MUL;
      rd_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign o_busy    = ((state_q == IDLE) && i_start && !i_flush) || (state_q == CALC);
  assign o_done    = (state_q == DONE) && !i_flush;
  assign o_result  = result_q;
  assign o_rd_addr = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, fast paths, flush and reset.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_addr;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  ex_muldiv dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_start    (start),
    .i_funct3   (funct3),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_rd_addr  (rd_addr),
    .i_flush    (flush),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_rd_addr  (rd_out)
  );

  always #5 clk = ~clk;

  // Drivers: inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_addr = rd;
  endtask

  task automatic wait_done(input bit hold, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    #1;
    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      #1;
      if (done === 1'b1) begin
        lat = c;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #2;
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; rd_addr = '0;
    #3;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (rd_out !== '0)   begin errors++; $display("FAIL reset_rd got %h exp 0", rd_out); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_mul;
    int lat; bit bok;
    logic [2:0]  f3 [3];
    logic [31:0] va [3], vb [3], ve [3];
    start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_done(1'b0, lat, bok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mul_busy got %b exp 1", bok); end
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got %h exp ffffffeb", result); end
    checks++; if (rd_out !== 5'd5) begin errors++; $display("FAIL mul_rd got %0d exp 5", rd_out); end
    f3[0] = 3'b001; va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; ve[0] = 32'h4000_0000;
    f3[1] = 3'b011; va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; ve[1] = 32'hFFFF_FFFE;
    f3[2] = 3'b010; va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; ve[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      start_op(f3[i], va[i], vb[i], 5'(10 + i));
      wait_done(1'b0, lat, bok);
      checks++; if (lat !== 33) begin errors++; $display("FAIL mulh_latency[%0d] got %0d exp 33", i, lat); end
      checks++; if (result !== ve[i]) begin errors++; $display("FAIL mulh_result[%0d] got %h exp %h", i, result, ve[i]); end
      checks++; if (rd_out !== 5'(10 + i)) begin errors++; $display("FAIL mulh_rd[%0d] got %0d exp %0d", i, rd_out, 10 + i); end
    end
  endtask

  task automatic test_div;
    int lat; bit bok;
    logic [2:0]  f3 [4];
    logic [31:0] va [4], vb [4], ve [4];
    f3[0] = 3'b100; va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2; ve[0] = 32'hFFFF_FFFD;
    f3[1] = 3'b110; va[1] = 32'hFFFF_FFF9; vb[1] = 32'd2; ve[1] = 32'hFFFF_FFFF;
    f3[2] = 3'b101; va[2] = 32'd100;       vb[2] = 32'd7; ve[2] = 32'd14;
    f3[3] = 3'b111; va[3] = 32'd100;       vb[3] = 32'd7; ve[3] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      start_op(f3[i], va[i], vb[i], 5'(20 + i));
      wait_done(1'b0, lat, bok);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d] got %0d exp 33", i, lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL div_busy[%0d] got %b exp 1", i, bok); end
      checks++; if (result !== ve[i]) begin errors++; $display("FAIL div_result[%0d] got %h exp %h", i, result, ve[i]); end
    end
  endtask

  task automatic test_fast_path;
    int lat; bit bok;
    logic [2:0]  f3 [4];
    logic [31:0] va [4], vb [4], ve [4];
    f3[0] = 3'b100; va[0] = 32'd5;         vb[0] = 32'd0;         ve[0] = 32'hFFFF_FFFF;
    f3[1] = 3'b110; va[1] = 32'd5;         vb[1] = 32'd0;         ve[1] = 32'd5;
    f3[2] = 3'b100; va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; ve[2] = 32'h8000_0000;
    f3[3] = 3'b110; va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; ve[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      start_op(f3[i], va[i], vb[i], 5'(1 + i));
      wait_done(1'b0, lat, bok);
      checks++; if (lat !== 1) begin errors++; $display("FAIL fast_latency[%0d] got %0d exp 1", i, lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL fast_busy[%0d] got %b exp 1", i, bok); end
      checks++; if (result !== ve[i]) begin errors++; $display("FAIL fast_result[%0d] got %h exp %h", i, result, ve[i]); end
      checks++; if (rd_out !== 5'(1 + i)) begin errors++; $display("FAIL fast_rd[%0d] got %0d exp %0d", i, rd_out, 1 + i); end
    end
  endtask

  task automatic test_flush;
    int lat, nd; bit bok;
    start_op(3'b101, 32'd100, 32'd7, 5'd3);
    wait_done(1'b0, lat, bok);
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_pre_result got %h exp 0000000e", result); end
    start_op(3'b100, 32'd1000, 32'd3, 5'd4);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", nd); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result_kept got %h exp 0000000e", result); end
    checks++; if (rd_out !== 5'd3) begin errors++; $display("FAIL flush_rd_kept got %0d exp 3", rd_out); end
    start_op(3'b000, 32'd3, 32'd4, 5'd6);
    wait_done(1'b0, lat, bok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL flush_next_latency got %0d exp 33", lat); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL flush_next_result got %h exp 0000000c", result); end
  endtask

  task automatic test_start_flush;
    int nd;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; rd_addr = 5'd7;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got %b exp 0", busy); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_idle got %b exp 0", busy); end
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("FAIL start_flush_no_done got %0d exp 0", nd); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL start_flush_result got %h exp 0000000c", result); end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok;
    start_op(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd8);
    wait_done(1'b0, lat, bok);
    checks++; if (lat !== 33 || result !== 32'd1) begin
      errors++; $display("FAIL b2b_first got lat %0d res %h exp lat 33 res 00000001", lat, result);
    end
    start_op(3'b110, 32'd17, 32'hFFFF_FFFB, 5'd9);
    wait_done(1'b0, lat, bok);
    checks++; if (lat !== 33 || result !== 32'd2 || rd_out !== 5'd9) begin
      errors++; $display("FAIL b2b_second got lat %0d res %h rd %0d exp lat 33 res 00000002 rd 9", lat, result, rd_out);
    end
  endtask

  task automatic test_hold_start;
    int lat, nd; bit bok;
    start_op(3'b000, 32'd6, 32'd7, 5'd11);
    wait_done(1'b1, lat, bok);
    checks++; if (lat !== 33 || result !== 32'd42) begin
      errors++; $display("FAIL hold_op got lat %0d res %h exp lat 33 res 0000002a", lat, result);
    end
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("FAIL hold_single_done got %0d extra exp 0", nd); end
  endtask

  task automatic test_reset_mid;
    int nd;
    start_op(3'b101, 32'd12345, 32'd10, 5'd13);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_mid_done got %b exp 0", done); end
    checks++; if (result !== '0)    begin errors++; $display("FAIL rst_mid_result got %h exp 0", result); end
    checks++; if (rd_out !== '0)    begin errors++; $display("FAIL rst_mid_rd got %0d exp 0", rd_out); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", dut.state_q); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d exp 0", nd); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_start_flush();
    test_back_to_back();
    test_hold_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
